// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared constants and FSM state encoding for the boot-time
//                instruction-memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Instruction memory geometry: 1024 words = 4 KB
    localparam int          c_IM_ADDR_W = 10;
    localparam int          c_IM_DEPTH  = 1 << c_IM_ADDR_W;

    // Frame start marker
    localparam logic [7:0]  c_SYNC_BYTE = 8'hA5;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_byte_packer
//  Description : 4 x 8-bit -> 32-bit big-endian word assembler. The first
//                byte of a word lands in [31:24]. word_valid pulses for one
//                cycle after the fourth byte, with word_out holding the word.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Shift bytes in MSB first; publish the completed word on the 4th byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (clear) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= byte_valid && (r_idx == 2'd3);
            if (byte_valid) begin
                r_shift <= {r_shift[15:0], byte_in};
                r_idx   <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_word <= {r_shift, byte_in};
                end
            end
        end
    end

    assign byte_idx   = r_idx;
    assign word_out   = r_word;
    assign word_valid = r_word_valid;

endmodule : imem_loader_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader. Parses a framed byte stream
//                (sync, 16-bit word count, big-endian words, XOR checksum),
//                writes words into instruction memory and holds the core in
//                reset until a good frame has been fully loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = c_IM_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              im_we,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    // Largest legal word count: fills the memory exactly
    localparam logic [31:0] c_MAX_LEN = 32'(1) << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [7:0]        r_chk;
    logic              r_rx_ready;
    logic [ADDR_W-1:0] r_im_waddr;
    logic              r_core_rst;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_xfer;
    logic              w_sync_xfer;
    logic              w_data_xfer;
    logic              w_word_done;
    logic              w_last_word;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_wcnt_inc;
    logic [1:0]        w_byte_idx;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_sync_xfer = w_xfer && (r_state == ST_IDLE) && (rx_data == SYNC_BYTE);
    assign w_data_xfer = w_xfer && (r_state == ST_DATA);
    assign w_word_done = w_data_xfer && (w_byte_idx == 2'd3);
    assign w_len_full  = {r_len[15:8], rx_data};
    assign w_wcnt_inc  = r_wcnt + 1'b1;
    assign w_last_word = w_word_done && (32'(w_wcnt_inc) == 32'(r_len));

    // Next-state decode; the FSM only moves on an accepted byte
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            unique case (r_state)
                ST_IDLE:   if (rx_data == SYNC_BYTE) w_state_nxt = ST_LEN_HI;
                ST_LEN_HI: w_state_nxt = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (w_len_full == 16'd0)
                        w_state_nxt = ST_CHK;
                    else if (32'(w_len_full) > c_MAX_LEN)
                        w_state_nxt = ST_ERR;
                    else
                        w_state_nxt = ST_DATA;
                end
                ST_DATA:   if (w_last_word) w_state_nxt = ST_CHK;
                ST_CHK:    w_state_nxt = (rx_data == r_chk) ? ST_DONE : ST_ERR;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // State, header/counter/checksum registers and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_chk       <= '0;
            r_rx_ready  <= 1'b0;
            r_im_waddr  <= '0;
            r_core_rst  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= (w_state_nxt != ST_DONE) && (w_state_nxt != ST_ERR);
            r_load_done <= (w_state_nxt == ST_DONE);
            r_load_err  <= (w_state_nxt == ST_ERR);
            r_core_rst  <= (w_state_nxt != ST_DONE);
            if (w_sync_xfer) begin
                r_chk  <= '0;
                r_wcnt <= '0;
            end
            if (w_xfer && (r_state == ST_LEN_HI)) r_len[15:8] <= rx_data;
            if (w_xfer && (r_state == ST_LEN_LO)) r_len[7:0]  <= rx_data;
            if (w_data_xfer) r_chk <= r_chk ^ rx_data;
            // Address is published alongside the packer's write strobe
            if (w_word_done) begin
                r_im_waddr <= r_wcnt[ADDR_W-1:0];
                r_wcnt     <= w_wcnt_inc;
            end
        end
    end

    imem_loader_byte_packer u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_sync_xfer),
        .byte_valid (w_data_xfer),
        .byte_in    (rx_data),
        .byte_idx   (w_byte_idx),
        .word_out   (im_wdata),
        .word_valid (im_we)
    );

    assign rx_ready  = r_rx_ready;
    assign im_waddr  = r_im_waddr;
    assign core_rst  = r_core_rst;
    assign load_done = r_load_done;
    assign load_err  = r_load_err;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int c_AW = 10;

    logic            clk;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [c_AW-1:0] im_waddr;
    logic [31:0]     im_wdata;
    logic            im_we;
    logic            core_rst;
    logic            load_done;
    logic            load_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]        frame[$];
    logic [c_AW+31:0]  wq[$];

    imem_loader #(.ADDR_W(c_AW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_waddr  (im_waddr),
        .im_wdata  (im_wdata),
        .im_we     (im_we),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen on the write port
    always @(negedge clk) begin
        if (im_we === 1'b1) wq.push_back({im_waddr, im_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Present one byte from a negedge until it is accepted on a rising edge
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = rx_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input int gap);
        foreach (frame[i]) begin
            send_byte(frame[i]);
            if (gap != 0) idle(1);
        end
    endtask

    // Reset with a byte presented at the same time; it must be ignored
    task automatic do_reset();
        rst      = 1'b1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        idle(2);
        rx_valid = 1'b0;
        rst      = 1'b0;
        idle(1);
        wq.delete();
    endtask

    task automatic build_std(input logic [7:0] chk);
        frame = '{8'hA5, 8'h00, 8'h02,
                  8'h24, 8'h08, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h0C, 8'h00};
        frame[11] = chk;
    endtask

    task automatic check_std_writes(input string tag);
        check({tag, "_nwr"}, 64'(wq.size()), 2);
        if (wq.size() == 2) begin
            check({tag, "_w0"}, 64'(wq[0]), {10'd0, 32'h24080005});
            check({tag, "_w1"}, 64'(wq[1]), {10'd1, 32'h0000000C});
        end
    endtask

    initial begin
        int          seq_err;
        logic [7:0]  fchk;
        logic [9:0]  ii;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // 1. reset values and rx_ready rising one cycle after release
        idle(2);
        check("rst_core_rst",  64'(core_rst),  1);
        check("rst_rx_ready",  64'(rx_ready),  0);
        check("rst_im_we",     64'(im_we),     0);
        check("rst_waddr",     64'(im_waddr),  0);
        check("rst_wdata",     64'(im_wdata),  0);
        check("rst_done",      64'(load_done), 0);
        check("rst_err",       64'(load_err),  0);
        rst = 1'b0;
        check("rel_ready_low", 64'(rx_ready),  0);
        idle(1);
        check("rel_ready_hi",  64'(rx_ready),  1);

        // 2. good frame
        wq.delete();
        build_std(8'h25);
        send_frame(0);
        check("good_done",     64'(load_done), 1);
        check("good_core_rst", 64'(core_rst),  0);
        check("good_ready",    64'(rx_ready),  0);
        check("good_err",      64'(load_err),  0);
        idle(2);
        check_std_writes("good");

        // 3. bad checksum
        do_reset();
        build_std(8'h26);
        send_frame(0);
        idle(2);
        check_std_writes("badchk");
        check("badchk_err",      64'(load_err),  1);
        check("badchk_done",     64'(load_done), 0);
        check("badchk_core_rst", 64'(core_rst),  1);
        check("badchk_ready",    64'(rx_ready),  0);

        // 4. leading garbage, valid toggled between bytes
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        build_std(8'h25);
        send_frame(1);
        idle(2);
        check_std_writes("gap");
        check("gap_done", 64'(load_done), 1);

        // 5a. length overflow 0x0401
        do_reset();
        frame = '{8'hA5, 8'h04, 8'h01};
        send_frame(0);
        check("ovf_err",   64'(load_err), 1);
        check("ovf_ready", 64'(rx_ready), 0);
        check("ovf_crst",  64'(core_rst), 1);
        idle(2);
        check("ovf_nwr",   64'(wq.size()), 0);

        // 5b. zero length
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("zero_done", 64'(load_done), 1);
        check("zero_crst", 64'(core_rst),  0);
        idle(2);
        check("zero_nwr",  64'(wq.size()), 0);

        // 5c. length 0x0400 fills memory exactly; word i holds value i
        do_reset();
        frame = '{8'hA5, 8'h04, 8'h00};
        fchk = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            ii = 10'(i);
            frame.push_back(8'h00);
            frame.push_back(8'h00);
            frame.push_back({6'd0, ii[9:8]});
            frame.push_back(ii[7:0]);
            fchk = fchk ^ {6'd0, ii[9:8]} ^ ii[7:0];
        end
        frame.push_back(fchk);
        send_frame(0);
        idle(2);
        check("full_done", 64'(load_done), 1);
        check("full_nwr",  64'(wq.size()), 1024);
        seq_err = 0;
        foreach (wq[i]) begin
            if (wq[i] !== {10'(i), 32'(i)}) seq_err++;
        end
        check("full_seq", 64'(seq_err), 0);

        // 6. reset after six data bytes, then resend
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
        send_frame(0);
        rst = 1'b1;
        idle(1);
        check("abort_crst", 64'(core_rst), 1);
        check("abort_we",   64'(im_we),    0);
        rst = 1'b0;
        idle(3);
        check("abort_nwr",  64'(wq.size()), 1);
        if (wq.size() == 1) check("abort_w0", 64'(wq[0]), {10'd0, 32'h24080005});
        wq.delete();
        build_std(8'h25);
        send_frame(0);
        check("resend_done", 64'(load_done), 1);
        check("resend_crst", 64'(core_rst),  0);
        idle(2);
        check_std_writes("resend");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
